fifo_read_serializer: RTL and testbench

//   Downstream consumer of the pointer-based FIFO datapath. Pops one J-word read burst when the

---
 rtl/fifo_read_serializer_if.sv | 49 ++++
 rtl/fifo_read_serializer.sv | 102 ++++++++++
 tb/tb_fifo_read_serializer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_serializer_if.sv
// ============================================================================
// Module   : fifo_read_serializer_if
// Brief    : FIFO read-side and serial-output handshake bundle for the serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_read_serializer_if #(
    parameter int J = 4,
    parameter int W = 4
);
    logic             clr;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [J*W-1:0]   fifo_rdata;
    logic             out_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    // Serializer side
    modport master (
        input  clr,
        input  fifo_empty,
        output fifo_rd,
        input  fifo_rdata,
        output out_bit,
        output out_valid,
        input  out_ready,
        output out_last,
        output busy
    );

    // FIFO / consumer side
    modport slave (
        output clr,
        output fifo_empty,
        input  fifo_rd,
        output fifo_rdata,
        input  out_bit,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/fifo_read_serializer.sv
// ============================================================================
// Module   : fifo_read_serializer
// Brief    : Pops one J-word FIFO burst and streams it MSB first, one bit per beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_serializer #(
    parameter int J = 4,
    parameter int W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fifo_read_serializer_if.master bus
);

    localparam int c_LEN   = J * W;
    localparam int c_CNT_W = $clog2(c_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_LEN-1:0]     r_shreg;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_fifo_rd;
    logic                 w_out_valid;
    logic                 w_beat;
    logic                 w_last;

    assign w_out_valid = (r_state == S_SHIFT);
    assign w_beat      = w_out_valid & bus.out_ready;
    assign w_last      = (r_cnt == c_CNT_W'(1));

    always_comb begin
        w_next_state = r_state;
        w_fifo_rd    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    w_fifo_rd    = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                // Refill on the final beat so back-to-back bursts lose only the LOAD cycle
                if (w_beat && w_last) begin
                    if (!bus.fifo_empty) begin
                        w_fifo_rd    = 1'b1;
                        w_next_state = S_LOAD;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (bus.clr) begin
            w_next_state = S_IDLE;
            w_fifo_rd    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (bus.clr) begin
                r_shreg <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_LOAD) begin
                r_shreg <= bus.fifo_rdata;
                r_cnt   <= c_CNT_W'(c_LEN);
            end else if (w_beat) begin
                r_shreg <= {r_shreg[c_LEN-2:0], 1'b0};
                r_cnt   <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    // fifo_rd is combinational from fifo_empty, so hold it low while reset is asserted
    assign bus.fifo_rd   = w_fifo_rd & rst;
    assign bus.out_valid = w_out_valid;
    assign bus.out_bit   = w_out_valid & r_shreg[c_LEN-1];
    assign bus.out_last  = w_out_valid & w_last;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_serializer.sv
// ============================================================================
// Module   : tb_fifo_read_serializer
// Brief    : Randomized bench with a FIFO/bit-queue reference model of the serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_read_serializer;

    localparam int c_J   = 4;
    localparam int c_W   = 4;
    localparam int c_LEN = c_J * c_W;

    logic clk;
    logic rst;

    fifo_read_serializer_if #(.J(c_J), .W(c_W)) bus ();

    fifo_read_serializer #(.J(c_J), .W(c_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words waiting in the FIFO, and the bit stream owed to the consumer
    logic [c_LEN-1:0] fq[$];
    logic [1:0]       eq[$];   // {bit, last}
    int               n_beats;
    int               gap_stage;
    logic             hold_pending;
    logic             held_bit;
    logic             held_last;
    logic             clr_after;
    logic             force_empty;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        eq.delete();
        gap_stage    = 0;
        hold_pending = 1'b0;
        clr_after    = 1'b0;
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step(input logic clr_v, input logic ready_v);
        logic             rd;
        logic [1:0]       e;
        logic [c_LEN-1:0] w;
        bus.fifo_empty = (fq.size() == 0) || force_empty;
        bus.clr        = clr_v;
        bus.out_ready  = ready_v;
        w              = '0;
        #1;
        if (hold_pending) begin
            check_eq("hold_valid", bus.out_valid, 1'b1);
            check_eq("hold_bit", bus.out_bit, held_bit);
            check_eq("hold_last", bus.out_last, held_last);
            hold_pending = 1'b0;
        end
        if (gap_stage == 1) begin
            check_eq("load_gap_valid", bus.out_valid, 1'b0);
            check_eq("load_gap_busy", bus.busy, 1'b1);
            gap_stage = 2;
        end else if (gap_stage == 2) begin
            check_eq("first_valid", bus.out_valid, 1'b1);
            gap_stage = 0;
        end
        if (clr_after) begin
            check_eq("clr_valid", bus.out_valid, 1'b0);
            check_eq("clr_busy", bus.busy, 1'b0);
            clr_after = 1'b0;
        end
        check_eq("last_without_valid", bus.out_last & ~bus.out_valid, 1'b0);
        if (clr_v)
            check_eq("clr_no_rd", bus.fifo_rd, 1'b0);
        if (bus.out_valid && ready_v) begin
            if (eq.size() == 0) begin
                check_eq("spurious_beat", 1'b1, 1'b0);
            end else begin
                e = eq.pop_front();
                check_eq("bit", bus.out_bit, e[1]);
                check_eq("last", bus.out_last, e[0]);
                if (e[0] && !clr_v && !bus.fifo_empty)
                    check_eq("b2b_rd", bus.fifo_rd, 1'b1);
                n_beats++;
            end
        end
        if (bus.out_valid && !ready_v && !clr_v) begin
            hold_pending = 1'b1;
            held_bit     = bus.out_bit;
            held_last    = bus.out_last;
        end
        rd = bus.fifo_rd;
        if (rd && !clr_v) begin
            if (bus.fifo_empty) begin
                check_eq("rd_when_empty", 1'b1, 1'b0);
            end else begin
                w = fq.pop_front();
                for (int i = c_LEN - 1; i >= 0; i--)
                    eq.push_back({w[i], (i == 0)});
                gap_stage = 1;
            end
        end
        if (clr_v) begin
            eq.delete();
            clr_after    = 1'b1;
            hold_pending = 1'b0;
            gap_stage    = 0;
        end
        @(posedge clk);
        #1;
        bus.fifo_rdata = (rd && !clr_v) ? w : c_LEN'($urandom);
        @(negedge clk);
    endtask

    task automatic drain(input logic rand_ready);
        int guard;
        guard = 0;
        while ((eq.size() != 0 || fq.size() != 0 || gap_stage != 0) && guard < 400) begin
            step(1'b0, rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
            guard++;
        end
        check_eq("drain_timeout", (guard >= 400), 1'b0);
        bus.fifo_empty = 1'b1;
        bus.clr        = 1'b0;
        #1;
        check_eq("idle_busy", bus.busy, 1'b0);
        check_eq("idle_valid", bus.out_valid, 1'b0);
        check_eq("idle_rd", bus.fifo_rd, 1'b0);
        clr_after = 1'b0;
    endtask

    task automatic step_until_rd();
        int guard;
        guard = 0;
        while (gap_stage != 1 && guard < 20) begin
            step(1'b0, 1'b1);
            guard++;
        end
        check_eq("rd_timeout", (guard >= 20), 1'b0);
    endtask

    task automatic step_until_beats(input int target);
        int guard;
        guard = 0;
        while (n_beats < target && guard < 100) begin
            step(1'b0, 1'b1);
            guard++;
        end
        check_eq("beat_timeout", (guard >= 100), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        force_empty    = 1'b0;
        n_beats        = 0;
        model_reset();
        rst            = 1'b0;
        bus.clr        = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.out_ready  = 1'b1;
        bus.fifo_rdata = '0;
        #1;
        check_eq("rst_rd", bus.fifo_rd, 1'b0);
        check_eq("rst_valid", bus.out_valid, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_bit", bus.out_bit, 1'b0);
        check_eq("rst_last", bus.out_last, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single burst with constant ready
        fq.push_back(16'hA5C3);
        drain(1'b0);

        // FIFO empty: nothing happens
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            check_eq("empty_rd", bus.fifo_rd, 1'b0);
            check_eq("empty_valid", bus.out_valid, 1'b0);
            check_eq("empty_busy", bus.busy, 1'b0);
        end

        // Backpressure at beat 3
        n_beats = 0;
        fq.push_back(16'hF00F);
        step_until_beats(2);
        repeat (5) step(1'b0, 1'b0);
        drain(1'b0);

        // Back-to-back bursts
        fq.push_back(16'h1234);
        fq.push_back(16'hFEDC);
        drain(1'b0);

        // clr in LOAD, then a fresh burst
        fq.push_back(c_LEN'($urandom));
        step_until_rd();
        step(1'b1, 1'b1);
        fq.push_back(c_LEN'($urandom));
        drain(1'b0);

        // clr on beat 7, then a fresh burst
        n_beats = 0;
        fq.push_back(c_LEN'($urandom));
        step_until_beats(6);
        step(1'b1, 1'b1);
        fq.push_back(c_LEN'($urandom));
        drain(1'b0);

        // Asynchronous reset mid-burst
        n_beats = 0;
        fq.push_back(c_LEN'($urandom));
        step_until_beats(5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst_rd", bus.fifo_rd, 1'b0);
        check_eq("arst_valid", bus.out_valid, 1'b0);
        check_eq("arst_busy", bus.busy, 1'b0);
        check_eq("arst_bit", bus.out_bit, 1'b0);
        check_eq("arst_last", bus.out_last, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        fq.push_back(16'h8001);
        drain(1'b0);

        // Randomized traffic: sporadic pushes, random ready, rare clr
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0 && fq.size() < 4)
                fq.push_back(c_LEN'($urandom));
            force_empty = ($urandom_range(0, 15) == 0);
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0));
        end
        force_empty = 1'b0;
        drain(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
